// File: rtl/pc_pkg.sv
// pc_pkg: shared state and next-PC select encodings for pc_sequencer
package pc_pkg;
  typedef enum logic {PC_RUN, PC_HALTED} pc_state_e;
  typedef enum logic [2:0] {SEL_SEQ, SEL_BRANCH, SEL_RET, SEL_JAL, SEL_TRAP, SEL_HOLD} pc_sel_e;
endpackage

// File: rtl/return_address_stack.sv
// return_address_stack: circular return-address stack that overwrites its oldest entry when full
module return_address_stack #(
  parameter int XLEN = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic            underflow
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  logic [XLEN-1:0] mem [RAS_DEPTH];
  logic [PW-1:0] ptr, ptr_inc, ptr_dec, wr_idx;
  logic [CW-1:0] count;
  logic swap;
  assign empty = count == '0;
  assign top = mem[ptr];
  assign swap = push && pop && !empty;
  assign ptr_inc = ptr == PW'(RAS_DEPTH - 1) ? '0 : ptr + 1'b1;
  assign ptr_dec = ptr == '0 ? PW'(RAS_DEPTH - 1) : ptr - 1'b1;
  assign wr_idx = swap ? ptr : ptr_inc;
  // pointer/count bookkeeping; a simultaneous push and pop replaces the top in place
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      ptr <= '0;
      count <= '0;
      underflow <= 1'b0;
    end else begin
      underflow <= pop && empty;
      if (push && !swap) begin
        ptr <= ptr_inc;
        count <= count == CW'(RAS_DEPTH) ? count : count + 1'b1;
      end else if (pop && !push && !empty) begin
        ptr <= ptr_dec;
        count <= count - 1'b1;
      end
    end
  // entry storage needs no reset: count gates every read
  always_ff @(posedge clock)
    if (push) mem[wr_idx] <= push_data;
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC with stall, halt/resume, trap redirect and misaligned fault; PC_RAS_EN adds a return-address stack
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR = 'h100,
  parameter int INST_BYTES = 4,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            stall,
  input  logic            is_halt,
  input  logic            resume,
  input  logic            trap_req,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            is_jal,
  input  logic [XLEN-1:0] imm_j,
  input  logic            is_call,
  input  logic            is_ret,
  output logic [XLEN-1:0] program_counter_value,
  output logic            halted,
  output logic            misaligned_fault,
  output logic            ras_empty,
  output logic            ras_underflow
);
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INST_BYTES - 1);
  pc_state_e state, state_n;
  pc_sel_e sel;
  logic [XLEN-1:0] pc_seq, ras_top, ret_target, target, pc_n;
  logic accept, ret_en, redirect, misaligned;
  assign pc_seq = program_counter_value + XLEN'(INST_BYTES);
  assign accept = state == PC_RUN && !stall && !trap_req;
  assign halted = state == PC_HALTED;
`ifdef PC_RAS_EN
  assign ret_en = is_ret;
  return_address_stack #(.XLEN(XLEN), .RAS_DEPTH(RAS_DEPTH)) u_ras (
    .clock(clock),
    .reset(reset),
    .push(accept && is_call),
    .pop(accept && is_ret),
    .push_data(pc_seq),
    .top(ras_top),
    .empty(ras_empty),
    .underflow(ras_underflow)
  );
`else
  logic unused_ras;
  assign unused_ras = is_call ^ is_ret ^ accept;
  assign ret_en = 1'b0;
  assign ras_top = pc_seq;
  assign ras_empty = 1'b1;
  assign ras_underflow = 1'b0;
`endif
  assign ret_target = ras_empty ? pc_seq : ras_top;
  // next-PC source select, redirect target and alignment check; next FSM state
  always_comb begin
    sel = trap_req ? SEL_TRAP : stall ? SEL_HOLD :
          state == PC_HALTED ? (resume ? SEL_SEQ : SEL_HOLD) :
          branch_taken ? SEL_BRANCH : ret_en ? SEL_RET : is_jal ? SEL_JAL :
          is_halt ? SEL_HOLD : SEL_SEQ;
    target = sel == SEL_BRANCH ? branch_target : sel == SEL_RET ? ret_target :
             program_counter_value + imm_j;
    redirect = sel == SEL_BRANCH || sel == SEL_RET || sel == SEL_JAL;
    misaligned = redirect && |(target & ALIGN_MASK);
    pc_n = (sel == SEL_TRAP || misaligned) ? TRAP_VECTOR : redirect ? target :
           sel == SEL_SEQ ? pc_seq : program_counter_value;
    state_n = trap_req ? PC_RUN : stall ? state :
              state == PC_HALTED ? (resume ? PC_RUN : PC_HALTED) :
              sel == SEL_HOLD ? PC_HALTED : PC_RUN;
  end
  // PC, run/halt state and sticky misaligned fault
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      program_counter_value <= RESET_VECTOR;
      state <= PC_RUN;
      misaligned_fault <= 1'b0;
    end else begin
      program_counter_value <= pc_n;
      state <= state_n;
      misaligned_fault <= misaligned_fault | misaligned;
    end
endmodule
